y86_instr_encoder: RTL

- Write-side counterpart of the fetch stage: accepts one decoded Y86-64 instruction (icode, ifun, rA, rB, valC) per handshake.
- Serializes it into instruction-memory bytes, one byte per cycle, in exactly the layout fetch decodes.
- Used to load programs into instruction memory for the sequential core and its benches; reports the address following the last byte written, which equals fetch's valP for that instruction.

---
 rtl/y86_instr_encoder_if.sv | 32 +++
 rtl/y86_instr_encoder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/y86_instr_encoder_if.sv
// Instruction-in / byte-write-out bundle for the Y86-64 instruction encoder.
// The encoder binds to the slave modport; the loader driving it uses the master modport.
interface y86_instr_encoder_if #(
   parameter int n = 64
);
   logic [n-1:0] base_addr;
   logic         load_base;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   icode;
   logic [3:0]   ifun;
   logic [3:0]   rA;
   logic [3:0]   rB;
   logic [n-1:0] valC;
   logic         mem_wr_en;
   logic         mem_wr_ready;
   logic [n-1:0] mem_addr;
   logic [7:0]   mem_wr_data;
   logic [n-1:0] next_pc;
   logic         done;
   logic         err;

   modport slave (
      input  base_addr, load_base, in_valid, icode, ifun, rA, rB, valC, mem_wr_ready,
      output in_ready, mem_wr_en, mem_addr, mem_wr_data, next_pc, done, err
   );

   modport master (
      output base_addr, load_base, in_valid, icode, ifun, rA, rB, valC, mem_wr_ready,
      input  in_ready, mem_wr_en, mem_addr, mem_wr_data, next_pc, done, err
   );
endinterface

// File: rtl/y86_instr_encoder.sv
// Serializes one decoded Y86-64 instruction into memory bytes in fetch layout.
// Define ENC_STRICT_EN to also reject bad ifun / register fields at acceptance.
module y86_instr_encoder #(
   parameter int n = 64
) (
   input logic                 clk,
   input logic                 rst_n,
   y86_instr_encoder_if.slave  bus
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t       state;
   logic [n-1:0] wptr;
   logic [3:0]   idx;
   logic [3:0]   last_idx;
   logic [3:0]   icode_q;
   logic [3:0]   ifun_q;
   logic [3:0]   ra_q;
   logic [3:0]   rb_q;
   logic [n-1:0] valc_q;
   logic         in_ready_q;
   logic         done_q;
   logic         err_q;

   logic         accept_ok;
   logic         fields_ok;
   logic         has_reg;
   logic [3:0]   valc_idx;
   logic [7:0]   byte_sel;

   function automatic logic [3:0] last_index(input logic [3:0] ic);
      case (ic)
         4'h0, 4'h1, 4'h9:       return 4'd0;
         4'h2, 4'h6, 4'hA, 4'hB: return 4'd1;
         4'h7, 4'h8:             return 4'd8;
         4'h3, 4'h4, 4'h5:       return 4'd9;
         default:                return 4'd0;
      endcase
   endfunction

`ifdef ENC_STRICT_EN
   always_comb begin
      fields_ok = 1'b1;
      case (bus.icode)
         4'h2, 4'h7: fields_ok = (bus.ifun <= 4'd6);
         4'h6:       fields_ok = (bus.ifun <= 4'd3);
         default:    fields_ok = (bus.ifun == 4'd0);
      endcase
      if (bus.icode == 4'h3 && bus.rA != 4'hF)
         fields_ok = 1'b0;
      if ((bus.icode == 4'hA || bus.icode == 4'hB) && bus.rB != 4'hF)
         fields_ok = 1'b0;
   end
`else
   assign fields_ok = 1'b1;
`endif

   assign accept_ok = (bus.icode < 4'hC) && fields_ok;

   // valC starts right after the register byte when there is one, else after byte0.
   assign has_reg  = (icode_q inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
   assign valc_idx = idx - (has_reg ? 4'd2 : 4'd1);

   // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
   always_comb begin
      byte_sel = 8'h00;
      if (idx == 4'd0)
         byte_sel = {icode_q, ifun_q};
      else if (has_reg && idx == 4'd1)
         byte_sel = {ra_q, rb_q};
      else
         byte_sel = valc_q[{valc_idx[2:0], 3'b000} +: 8];
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wptr       <= '0;
         idx        <= '0;
         last_idx   <= '0;
         icode_q    <= '0;
         ifun_q     <= '0;
         ra_q       <= '0;
         rb_q       <= '0;
         valc_q     <= '0;
         in_ready_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (bus.load_base)
                  wptr <= bus.base_addr;
               if (bus.in_valid && in_ready_q) begin
                  if (accept_ok) begin
                     icode_q    <= bus.icode;
                     ifun_q     <= bus.ifun;
                     ra_q       <= bus.rA;
                     rb_q       <= bus.rB;
                     valc_q     <= bus.valC;
                     last_idx   <= last_index(bus.icode);
                     idx        <= 4'd0;
                     in_ready_q <= 1'b0;
                     state      <= EMIT;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (bus.mem_wr_ready) begin
                  wptr <= wptr + n'(1);
                  if (idx == last_idx) begin
                     state      <= IDLE;
                     done_q     <= 1'b1;
                     in_ready_q <= 1'b1;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Write address and data derive only from flops, so they hold steady under backpressure.
   assign bus.in_ready    = in_ready_q;
   assign bus.mem_wr_en   = (state == EMIT);
   assign bus.mem_addr    = wptr;
   assign bus.mem_wr_data = (state == EMIT) ? byte_sel : 8'h00;
   assign bus.next_pc     = wptr;
   assign bus.done        = done_q;
   assign bus.err         = err_q;

endmodule
